// File: rtl/glitch_detect_pkg.sv
// Shared constants and types for the glitch detector: event payload layout and history fill state.
package glitch_detect_pkg;

    localparam int MASK_LSB = 0;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_t;

    function automatic int evt_width(input int sdw, input int tsw);
        return sdw + tsw;
    endfunction

    // Timestamp sits directly above the channel mask.
    function automatic int ts_lsb(input int sdw);
        return sdw;
    endfunction

endpackage

// File: rtl/glitch_window.sv
// Two-sample history window; flags channels whose middle sample differs from equal neighbours.
// Mask is combinational on the current sample; history advances one step per enabled transfer.
module glitch_window
    import glitch_detect_pkg::*;
#(
    parameter int SDW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_ena,
    input  logic           i_xfer,
    input  logic [SDW-1:0] i_dat,
    output logic [SDW-1:0] o_mask
);

    logic [SDW-1:0] r_h1;
    logic [SDW-1:0] r_h2;
    fill_t          r_fill;
    fill_t          w_fill_nxt;

    always_comb begin
        w_fill_nxt = r_fill;
        case (r_fill)
            FILL_EMPTY: w_fill_nxt = FILL_ONE;
            FILL_ONE:   w_fill_nxt = FILL_FULL;
            default:    w_fill_nxt = FILL_FULL;
        endcase
    end

    // Dropping enable forgets all history so detection restarts from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1   <= '0;
            r_h2   <= '0;
            r_fill <= FILL_EMPTY;
        end else if (!i_ena) begin
            r_h1   <= '0;
            r_h2   <= '0;
            r_fill <= FILL_EMPTY;
        end else if (i_xfer) begin
            r_h2   <= r_h1;
            r_h1   <= i_dat;
            r_fill <= w_fill_nxt;
        end
    end

    always_comb begin
        o_mask = '0;
        if (i_ena && (r_fill == FILL_FULL))
            o_mask = (r_h1 ^ r_h2) & ~(i_dat ^ r_h2);
    end

endmodule

// File: rtl/glitch_detect.sv
// Reports single-sample glitches as {timestamp, mask} events; event registered 1 cycle after confirming sample.
// A pending unaccepted event deasserts sti_tready, so events are never dropped.
module glitch_detect
    import glitch_detect_pkg::*;
#(
    parameter int SDW = 32,
    parameter int TSW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    output logic             sti_tready,
    input  logic             sti_tvalid,
    input  logic [SDW-1:0]   sti_tdata,
    input  logic             sto_tready,
    output logic             sto_tvalid,
    output logic [TSW+SDW-1:0] sto_tdata
);

    localparam int EVTW   = evt_width(SDW, TSW);
    localparam int TS_LSB = ts_lsb(SDW);

    logic [TSW-1:0]  r_ts;
    logic            r_vld;
    logic [EVTW-1:0] r_dat;
    logic            w_xfer;
    logic            w_load;
    logic [SDW-1:0]  w_mask;
    logic [TSW-1:0]  w_ts_prev;
    logic [EVTW-1:0] w_evt;

    assign sti_tready = sto_tready | ~r_vld;
    assign w_xfer     = sti_tvalid & sti_tready;
    assign w_load     = w_xfer & ena & (|w_mask);
    // The glitch is the previous sample, one index behind the arriving one.
    assign w_ts_prev  = r_ts - TSW'(1);

    glitch_window #(
        .SDW (SDW)
    ) u_window (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ena  (ena),
        .i_xfer (w_xfer),
        .i_dat  (sti_tdata),
        .o_mask (w_mask)
    );

    always_comb begin
        w_evt = '0;
        w_evt[TS_LSB +: TSW]   = w_ts_prev;
        w_evt[MASK_LSB +: SDW] = w_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ts <= '0;
        else if (!ena)
            r_ts <= '0;
        else if (w_xfer)
            r_ts <= r_ts + TSW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (w_load) begin
            r_vld <= 1'b1;
            r_dat <= w_evt;
        end else if (sto_tready) begin
            r_vld <= 1'b0;
        end
    end

    assign sto_tvalid = r_vld;
    assign sto_tdata  = r_dat;

endmodule

// File: tb/tb_glitch_detect.sv
// Directed-vector bench for glitch_detect with a queue scoreboard drained by an independent monitor.
module tb_glitch_detect;

    localparam int SDW = 4;
    localparam int TSW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b1;
    logic            sti_tready;
    logic            sti_tvalid = 1'b0;
    logic [SDW-1:0]  sti_tdata = '0;
    logic            sto_tready = 1'b1;
    logic            sto_tvalid;
    logic [TSW+SDW-1:0] sto_tdata;

    int checks = 0;
    int failures = 0;
    logic [TSW+SDW-1:0] exp_q[$];

    always #5 clk = ~clk;

    glitch_detect #(
        .SDW (SDW),
        .TSW (TSW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sti_tready (sti_tready),
        .sti_tvalid (sti_tvalid),
        .sti_tdata  (sti_tdata),
        .sto_tready (sto_tready),
        .sto_tvalid (sto_tvalid),
        .sto_tdata  (sto_tdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change only 1 time unit after a rising edge; handshakes are sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && sto_tvalid && sto_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=0x%0h required=none", sto_tdata);
            end else begin
                logic [TSW+SDW-1:0] e;
                e = exp_q.pop_front();
                if (sto_tdata !== e) begin
                    failures++;
                    $display("FAIL event_payload actual=0x%0h required=0x%0h", sto_tdata, e);
                end
            end
        end
    end

    task automatic send(input logic [SDW-1:0] d);
        int  n;
        logic ok;
        n = 0;
        sti_tvalid = 1'b1;
        sti_tdata  = d;
        do begin
            @(negedge clk);
            ok = sti_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 20);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=transfer");
        end
        sti_tvalid = 1'b0;
    endtask

    task automatic restart();
        ena = 1'b0;
        @(posedge clk);
        #1;
        ena = 1'b1;
    endtask

    task automatic push(input logic [TSW-1:0] ts, input logic [SDW-1:0] m);
        exp_q.push_back({ts, m});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_vld", 32'(sto_tvalid), 32'd0);
        chk("rst_dat", 32'(sto_tdata), 32'd0);
        chk("rst_rdy", 32'(sti_tready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic glitch plus latency
        push(8'h01, 4'h1);
        send(4'h0);
        send(4'h1);
        chk("pre_evt_vld", 32'(sto_tvalid), 32'd0);
        send(4'h0);
        chk("latency_vld", 32'(sto_tvalid), 32'd1);
        chk("latency_dat", 32'(sto_tdata), 32'h011);

        // Steps are not glitches
        restart();
        send(4'h0); send(4'h3); send(4'h3); send(4'h0); send(4'h0);
        restart();
        push(8'h01, 4'hF);
        push(8'h02, 4'hF);
        send(4'h5); send(4'hA); send(4'h5); send(4'hA);

        // Backpressure: stalled sample must not advance ts or history
        restart();
        sto_tready = 1'b0;
        push(8'h01, 4'h1);
        push(8'h02, 4'h1);
        push(8'h03, 4'h1);
        send(4'h0); send(4'h1); send(4'h0);
        sti_tvalid = 1'b1;
        sti_tdata  = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdy", 32'(sti_tready), 32'd0);
            chk("stall_dat", 32'(sto_tdata), 32'h011);
        end
        @(posedge clk);
        #1 sto_tready = 1'b1;
        @(negedge clk);
        chk("unstall_rdy", 32'(sti_tready), 32'd1);
        @(posedge clk);
        #1;
        chk("replace_vld", 32'(sto_tvalid), 32'd1);
        send(4'h0);

        // Timestamp wrap
        restart();
        push(8'h01, 4'h8);
        for (int i = 0; i < 257; i++) send(4'h0);
        send(4'h8);
        send(4'h0);

        // Enable restart: nothing may span the gap
        restart();
        send(4'h0); send(4'h1);
        ena = 1'b0;
        repeat (2) @(posedge clk);
        #1 ena = 1'b1;
        push(8'h01, 4'h1);
        send(4'h0); send(4'h1); send(4'h0);

        // Async reset with a pending event
        restart();
        sto_tready = 1'b0;
        send(4'h0); send(4'h1); send(4'h0);
        chk("pend_vld", 32'(sto_tvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(sto_tvalid), 32'd0);
        chk("arst_dat", 32'(sto_tdata), 32'd0);
        chk("arst_rdy", 32'(sti_tready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        sto_tready = 1'b1;
        @(posedge clk);
        #1;
        push(8'h01, 4'h1);
        send(4'h1); send(4'h0);
        chk("fresh_no_evt", 32'(sto_tvalid), 32'd0);
        send(4'h1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glitch_detect.md
# glitch_detect

Sample-stream monitor that reports single-period glitches instead of removing them. It consumes the same valid/ready sample stream that feeds the glitch filter, using the same SDW-wide samples and handshake rules. It emits one event per glitching sample position, carrying a per-channel glitch mask and a sample-index timestamp. It sits beside the filter in the capture path, so the trigger and readout logic can see the glitches the filter suppresses.

## Interface
Parameters:
- SDW, 32, sample data width (channels)
- TSW, 16, timestamp width (sample index counter)

Ports:
- clk  input  1  clock; one clock domain
- rst_n  input  1  reset; asynchronous assertion, active-low
- ena  input  1  detection enable; low clears history and timestamp
- sti_tready  output  1  input stream ready
- sti_tvalid  input  1  input stream valid
- sti_tdata  input  SDW  input sample
- sto_tready  input  1  event stream ready
- sto_tvalid  output  1  event valid, registered
- sto_tdata  output  TSW+SDW  event payload: {timestamp[TSW-1:0], mask[SDW-1:0]}, registered

## Operation
- Input transfer: sti_tvalid & sti_tready.
- History registers:
  - h1 holds sample n-1 and h2 holds sample n-2.
  - fill is a 2-bit counter, 0..2, saturating at 2.
  - All three update only on an input transfer with ena=1.
- Timestamp counter ts:
  - Counts accepted samples while ena=1, wrapping modulo 2^TSW.
  - ts is the index of the sample currently arriving. The first sample after ena rises has index 0.
- Glitch mask, combinational on each transfer:
  - mask[i] = (fill==2) & (h1[i]^h2[i]) & ~(sti_tdata[i]^h2[i]).
  - This flags bit i when h1 differs from both of its neighbours, which are equal.
- Event generation:
  - A transfer with mask != 0 loads sto_tdata = {ts-1 (mod 2^TSW), mask} and sets sto_tvalid=1.
  - The timestamp ts-1 is the index of the glitch sample h1.
- Event retirement: sto_tvalid clears on sto_tready=1 when no new event loads in the same cycle.
- Backpressure: sti_tready = sto_tready | ~sto_tvalid. A pending, unaccepted event stalls the input stream; no event is ever dropped.
- Alternating patterns: each middle sample is reported separately. For example, 0,1,0,1 on one bit gives two events, at indices 1 and 2.
- ena=0:
  - fill and ts are held at 0, and no events are generated.
  - sti_tready still follows the backpressure rule.
  - Samples are accepted and discarded.
  - A pending event stays in the output register until it is accepted.
- ena toggling mid-stream restarts detection: the first glitch can be reported only on the third sample after re-enable.

## Timing
- Reset values:
  - sto_tvalid=0, sto_tdata=0, h1=h2=0, fill=0, ts=0.
  - sti_tready=1, since it is combinational from sto_tvalid=0.
- Latency: an event is visible on sto_tvalid in the cycle after the transfer of sample n, the sample that confirms the glitch at n-1.
- Throughput:
  - One sample per cycle when sto_tready=1.
  - Back-to-back events on consecutive cycles are supported.
- Simultaneous event accept and new event load: the new event replaces the old in the same cycle, and sto_tvalid stays 1.
- rst_n asserted mid-operation:
  - All state clears immediately, without waiting for clk.
  - A pending event is lost.
  - Release is synchronous to clk.
- sti_tvalid low: no state change, and ts does not advance.

## Structure
- Shared package:
  - Event payload width constant (TSW+SDW).
  - Field offsets: TS_LSB=SDW, MASK_LSB=0.
  - The history fill count type, which encodes the states EMPTY, ONE and FULL.
- Sub-module glitch_window: h1/h2 history, fill counter and mask generation, with the transfer and enable as inputs.
- Top level: timestamp counter, output event register and backpressure.

## Test plan
All scenarios use SDW=4, TSW=8.
- Reset: hold rst_n=0 -> sto_tvalid=0, sto_tdata=0, sti_tready=1. Release, then send 0x0,0x1,0x0 -> exactly one event {ts=0x01, mask=0x1}, one cycle after the third transfer.
- Steps are not glitches: send 0x0,0x3,0x3,0x0,0x0 -> no events. Send 0x5,0xA,0x5,0xA -> two events: {ts=1, mask=0xF} and {ts=2, mask=0xF}.
- Backpressure: hold sto_tready=0 after an event is produced, with sti_tvalid=1 -> sti_tready=0, and neither ts nor the history advances. Raise sto_tready -> the event is accepted and the stalled sample transfers in the same cycle.
- Wrap-around: send 257 samples of 0x0 followed by 0x8,0x0 -> event {ts=0x01, mask=0x8}, because the glitch index 257 wraps modulo 256.
- Enable restart: send 0x0,0x1, drop ena for 2 cycles, raise it, then send 0x0,0x1,0x0 -> only one event, with ts=1 counted from the re-enable, and no event spanning the gap.
- Async reset with an event pending and sto_tready=0: assert rst_n mid-cycle -> sto_tvalid drops immediately, without waiting for clk. After release, the first glitch needs 3 fresh samples.
